write_access_guard: RTL and testbench

//  Parametrised successor to the single-table write monitor. Checks every bus write against a
//  run-time programmable rule table (module ID + address window), blocks violators, and counts

---
 rtl/wag_pkg.sv | 34 +++
 rtl/wag_alert_fifo.sv | 97 +++++++++
 rtl/write_access_guard.sv | 153 +++++++++++++++
 tb/tb_write_access_guard.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wag_pkg.sv
// Shared types for write_access_guard: rule table entry, alert record and the
// alert holding-register state encoding.
package wag_pkg;

    localparam int WAG_ID_W   = 2;
    localparam int WAG_ADDR_W = 8;
    localparam int WAG_DATA_W = 8;

    typedef struct packed {
        logic                  en;
        logic [WAG_ID_W-1:0]   id;
        logic [WAG_ADDR_W-1:0] base;
        logic [WAG_ADDR_W-1:0] limit;
    } rule_t;

    typedef struct packed {
        logic [WAG_ID_W-1:0]   id;
        logic [WAG_ADDR_W-1:0] addr;
        logic [WAG_DATA_W-1:0] data;
    } alert_t;

    typedef enum logic {
        ALERT_EMPTY = 1'b0,
        ALERT_FULL  = 1'b1
    } alert_state_t;

    // Inclusive unsigned window; base > limit can never satisfy both bounds.
    function automatic logic rule_hit(input rule_t r,
                                      input logic [WAG_ID_W-1:0] id,
                                      input logic [WAG_ADDR_W-1:0] addr);
        return r.en && (r.id == id) && (r.base <= addr) && (addr <= r.limit);
    endfunction

endpackage

// File: rtl/wag_alert_fifo.sv
// Valid/ready buffer for alert records. DEPTH 1 is a two-state holding register;
// larger power-of-2 depths use a circular buffer. Push is accepted on a full
// buffer when a pop happens in the same cycle.
module wag_alert_fifo
    import wag_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid,
    output logic   push_ready,
    input  alert_t push_data,
    output logic   pop_valid,
    input  logic   pop_ready,
    output alert_t pop_data
);

    generate
        if (DEPTH == 1) begin : g_hold
            alert_state_t state_reg;
            alert_t       data_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ALERT_EMPTY;
                    data_reg  <= '0;
                end else begin
                    case (state_reg)
                        ALERT_EMPTY: begin
                            if (push_valid) begin
                                state_reg <= ALERT_FULL;
                                data_reg  <= push_data;
                            end
                        end
                        ALERT_FULL: begin
                            if (pop_ready) begin
                                if (push_valid) begin
                                    data_reg <= push_data;
                                end else begin
                                    state_reg <= ALERT_EMPTY;
                                end
                            end
                        end
                        default: state_reg <= ALERT_EMPTY;
                    endcase
                end
            end

            assign pop_valid  = (state_reg == ALERT_FULL);
            assign push_ready = (state_reg == ALERT_EMPTY) || pop_ready;
            assign pop_data   = data_reg;
        end else begin : g_fifo
            localparam int PTR_W  = $clog2(DEPTH);
            localparam int FILL_W = $clog2(DEPTH + 1);

            alert_t             mem [DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [FILL_W-1:0]  count_reg;
            logic               full;
            logic               do_push;
            logic               do_pop;

            assign full       = (count_reg == FILL_W'(DEPTH));
            assign pop_valid  = (count_reg != '0);
            assign push_ready = !full || pop_ready;
            assign do_pop     = pop_ready && pop_valid;
            assign do_push    = push_valid && push_ready;
            // Empty buffer presents zeros so the record fields are clean out of reset.
            assign pop_data   = pop_valid ? mem[rd_ptr_reg] : '0;

            always_ff @(posedge clk) begin
                if (do_push) begin
                    mem[wr_ptr_reg] <= push_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({do_push, do_pop})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: rtl/write_access_guard.sv
// Bus write firewall: programmable ID/address-window rules, per-ID violation
// counters with lockout, and a violation alert stream. Define ALERT_FIFO_EN for a deep alert FIFO.
module write_access_guard
    import wag_pkg::*;
#(
    parameter int ID_W        = WAG_ID_W,
    parameter int ADDR_W      = WAG_ADDR_W,
    parameter int DATA_W      = WAG_DATA_W,
    parameter int NUM_RULES   = 4,
    parameter int CNT_W       = 3,
    parameter int LOCK_THRESH = 3,
    parameter int ALERT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [ID_W-1:0]              wr_id,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         chk_valid,
    output logic                         chk_allow,
    output logic                         chk_block,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_RULES)-1:0] cfg_idx,
    input  logic                         cfg_en,
    input  logic [ID_W-1:0]              cfg_id,
    input  logic [ADDR_W-1:0]            cfg_base,
    input  logic [ADDR_W-1:0]            cfg_limit,
    input  logic                         unlock_we,
    input  logic [ID_W-1:0]              unlock_id,
    output logic [2**ID_W-1:0]           locked,
    output logic                         alert_valid,
    input  logic                         alert_ready,
    output logic [ID_W-1:0]              alert_id,
    output logic [ADDR_W-1:0]            alert_addr,
    output logic [DATA_W-1:0]            alert_data,
    output logic                         alert_ovf
);

    localparam int NUM_IDS = 2**ID_W;
    localparam int IDX_W   = $clog2(NUM_RULES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef ALERT_FIFO_EN
    localparam int ALERT_FIFO_DEPTH = ALERT_DEPTH;
`else
    localparam int ALERT_FIFO_DEPTH = (ALERT_DEPTH > 0) ? 1 : 1;
`endif

    logic [NUM_RULES-1:0] hit;
    logic                 allow;
    logic                 violation;
    logic                 chk_valid_reg;
    logic                 chk_allow_reg;
    logic                 chk_block_reg;
    logic                 alert_ovf_reg;
    logic                 push_ready;
    alert_t               alert_rec;

    // Rule table: a rule written this cycle only affects checks from the next cycle.
    generate
        for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
            rule_t rule_reg;

            assign hit[gi] = rule_hit(rule_reg, wr_id, wr_addr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rule_reg <= '0;
                end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
                    rule_reg <= '{en: cfg_en, id: cfg_id, base: cfg_base, limit: cfg_limit};
                end
            end
        end
    endgenerate

    assign allow     = (|hit) && !locked[wr_id];
    assign violation = wr_valid && !allow;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid_reg <= 1'b0;
            chk_allow_reg <= 1'b0;
            chk_block_reg <= 1'b0;
        end else begin
            chk_valid_reg <= wr_valid;
            chk_allow_reg <= wr_valid && allow;
            chk_block_reg <= violation;
        end
    end

    assign chk_valid = chk_valid_reg;
    assign chk_allow = chk_allow_reg;
    assign chk_block = chk_block_reg;

    // Per-ID saturating violation counter and lock; unlock beats a same-cycle violation.
    generate
        for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_id
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             lock_reg;
            logic             viol_here;
            logic             unlock_here;

            assign viol_here   = violation && (wr_id == ID_W'(gi));
            assign unlock_here = unlock_we && (unlock_id == ID_W'(gi));
            assign cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

            always_ff @(posedge clk) begin
                if (rst || unlock_here) begin
                    cnt_reg  <= '0;
                    lock_reg <= 1'b0;
                end else if (viol_here) begin
                    cnt_reg <= cnt_next;
                    if (cnt_next >= CNT_W'(LOCK_THRESH)) begin
                        lock_reg <= 1'b1;
                    end
                end
            end

            assign locked[gi] = lock_reg;
        end
    endgenerate

    wag_alert_fifo #(
        .DEPTH (ALERT_FIFO_DEPTH)
    ) u_alert (
        .clk        (clk),
        .rst        (rst),
        .push_valid (violation),
        .push_ready (push_ready),
        .push_data  ('{id: wr_id, addr: wr_addr, data: wr_data}),
        .pop_valid  (alert_valid),
        .pop_ready  (alert_ready),
        .pop_data   (alert_rec)
    );

    // A refused push means a record was lost; the flag clears on the next handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            alert_ovf_reg <= 1'b0;
        end else if (violation && !push_ready) begin
            alert_ovf_reg <= 1'b1;
        end else if (alert_valid && alert_ready) begin
            alert_ovf_reg <= 1'b0;
        end
    end

    assign alert_ovf  = alert_ovf_reg;
    assign alert_id   = alert_rec.id;
    assign alert_addr = alert_rec.addr;
    assign alert_data = alert_rec.data;

endmodule

// File: tb/tb_write_access_guard.sv
// Self-checking bench for write_access_guard: directed vector table, overflow and
// reset sequences, then random traffic against a queue-based reference model.
module tb_write_access_guard;

`ifdef ALERT_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [1:0] wr_id;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       chk_valid, chk_allow, chk_block;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic       cfg_en;
    logic [1:0] cfg_id;
    logic [7:0] cfg_base, cfg_limit;
    logic       unlock_we;
    logic [1:0] unlock_id;
    logic [3:0] locked;
    logic       alert_valid, alert_ready;
    logic [1:0] alert_id;
    logic [7:0] alert_addr, alert_data;
    logic       alert_ovf;

    always #5 clk = ~clk;

    write_access_guard dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_id(wr_id), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_valid(chk_valid), .chk_allow(chk_allow), .chk_block(chk_block),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_id(cfg_id),
        .cfg_base(cfg_base), .cfg_limit(cfg_limit),
        .unlock_we(unlock_we), .unlock_id(unlock_id), .locked(locked),
        .alert_valid(alert_valid), .alert_ready(alert_ready),
        .alert_id(alert_id), .alert_addr(alert_addr), .alert_data(alert_data),
        .alert_ovf(alert_ovf)
    );

    // Reference model state
    bit          m_en [4];
    int          m_id [4];
    int          m_base [4];
    int          m_limit [4];
    int          m_cnt [4];
    bit          m_lk [4];
    logic [17:0] m_q [$];
    bit          m_ovf;
    bit          e_cv, e_ca;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit wv; int id; int addr;
        bit cfg; int cidx; int cid; int cbase; int climit;
        bit unl; int uid;
        bit exp_allow; bit exp_block; int exp_locked;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit       allow;
        bit       viol;
        int       id;
        int       a;
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                m_en[r] = 0; m_id[r] = 0; m_base[r] = 0; m_limit[r] = 0;
                m_cnt[r] = 0; m_lk[r] = 0;
            end
            m_q.delete();
            m_ovf = 0; e_cv = 0; e_ca = 0;
            return;
        end
        id = int'(wr_id);
        a  = int'(wr_addr);
        allow = 0;
        for (int r = 0; r < 4; r++)
            if (m_en[r] && m_id[r] == id && m_base[r] <= a && a <= m_limit[r]) allow = 1;
        if (m_lk[id]) allow = 0;
        viol = wr_valid && !allow;
        if (alert_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_ovf = 0;
        end
        if (viol) begin
            if (m_q.size() < CAP) m_q.push_back({wr_id, wr_addr, wr_data});
            else m_ovf = 1;
            m_cnt[id] = (m_cnt[id] < 7) ? m_cnt[id] + 1 : 7;
            if (m_cnt[id] >= 3) m_lk[id] = 1;
        end
        if (unlock_we) begin
            m_cnt[int'(unlock_id)] = 0;
            m_lk[int'(unlock_id)]  = 0;
        end
        if (cfg_we) begin
            m_en[int'(cfg_idx)]    = cfg_en;
            m_id[int'(cfg_idx)]    = int'(cfg_id);
            m_base[int'(cfg_idx)]  = int'(cfg_base);
            m_limit[int'(cfg_idx)] = int'(cfg_limit);
        end
        e_cv = wr_valid;
        e_ca = wr_valid && allow;
    endtask

    task automatic compare_model();
        logic [3:0]  exp_lk;
        logic [17:0] exp_rec;
        logic [17:0] act_rec;
        for (int i = 0; i < 4; i++) exp_lk[i] = m_lk[i];
        exp_rec = (m_q.size() > 0) ? m_q[0] : 18'h0;
        act_rec = alert_valid ? {alert_id, alert_addr, alert_data} : 18'h0;
        check("chk", {chk_valid, chk_allow, chk_block}, {e_cv, e_ca, e_cv && !e_ca});
        check("locked", locked, exp_lk);
        check("alert", {alert_valid, act_rec}, {m_q.size() > 0, exp_rec});
        check("ovf", alert_ovf, m_ovf);
    endtask

    task automatic drive(input bit wv, input int id, input int addr,
                         input bit cfg, input int cidx, input bit cen, input int cid,
                         input int cb, input int cl, input bit unl, input int uid, input bit rdy);
        wr_valid = wv;  wr_id = id[1:0]; wr_addr = addr[7:0]; wr_data = 8'($urandom);
        cfg_we = cfg;   cfg_idx = cidx[1:0]; cfg_en = cen; cfg_id = cid[1:0];
        cfg_base = cb[7:0]; cfg_limit = cl[7:0];
        unlock_we = unl; unlock_id = uid[1:0]; alert_ready = rdy;
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        compare_model();
        $display("[TB] t=%0t wv=%0b id=%0d addr=%h -> allow=%0b block=%0b locked=%h alert_v=%0b ovf=%0b",
                 $time, wr_valid, wr_id, wr_addr, chk_allow, chk_block, locked, alert_valid, alert_ovf);
    endtask

    initial begin
        //           wv id addr  cfg idx cid base limit unl uid allow block locked
        vecs[0]  = '{1, 1, 'h10, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0};
        vecs[1]  = '{1, 1, 'h10, 1, 0, 1, 'h10, 'h1F, 1, 1, 0, 1, 0};
        vecs[2]  = '{1, 1, 'h10, 0, 0, 0, 0,    0,    0, 0, 1, 0, 0};
        vecs[3]  = '{1, 1, 'h1F, 0, 0, 0, 0,    0,    0, 0, 1, 0, 0};
        vecs[4]  = '{1, 1, 'h0F, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0};
        vecs[5]  = '{1, 1, 'h20, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0};
        vecs[6]  = '{1, 2, 'h10, 0, 0, 0, 0,    0,    1, 1, 0, 1, 0};
        vecs[7]  = '{1, 2, 'h00, 1, 1, 2, 'h40, 'h4F, 0, 0, 0, 1, 0};
        vecs[8]  = '{1, 2, 'h00, 0, 0, 0, 0,    0,    0, 0, 0, 1, 4};
        vecs[9]  = '{1, 2, 'h40, 0, 0, 0, 0,    0,    0, 0, 0, 1, 4};
        vecs[10] = '{0, 0, 'h00, 0, 0, 0, 0,    0,    1, 2, 0, 0, 0};
        vecs[11] = '{1, 2, 'h40, 0, 0, 0, 0,    0,    0, 0, 1, 0, 0};
        vecs[12] = '{1, 0, 'h10, 1, 2, 0, 'h30, 'h20, 0, 0, 0, 1, 0};
        vecs[13] = '{1, 0, 'h25, 0, 0, 0, 0,    0,    0, 0, 0, 1, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("rst_fields", {alert_id, alert_addr, alert_data}, 32'h0);
        check("rst_outputs", {chk_valid, chk_allow, chk_block, locked, alert_valid, alert_ovf}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wv, vecs[i].id, vecs[i].addr, vecs[i].cfg, vecs[i].cidx, 1'b1,
                  vecs[i].cid, vecs[i].cbase, vecs[i].climit, vecs[i].unl, vecs[i].uid, 1'b1);
            cycle();
            check($sformatf("vec%0d_allow", i), chk_allow, vecs[i].exp_allow);
            check($sformatf("vec%0d_block", i), chk_block, vecs[i].exp_block);
            check($sformatf("vec%0d_locked", i), locked, vecs[i].exp_locked[3:0]);
            if (i == 0) check("first_alert", {alert_valid, alert_id, alert_addr}, {1'b1, 2'd1, 8'h10});
        end

        // Alert overflow with a stalled consumer
        for (int k = 0; k <= CAP; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            cycle();
        end
        for (int k = 0; k <= CAP; k++) begin
            drive(1, 3, 'hA1 + k, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
            check(k < CAP ? "ovf_early" : "ovf_set", alert_ovf, (k < CAP) ? 32'd0 : 32'd1);
        end
        check("ovf_head", {alert_valid, alert_addr}, {1'b1, 8'hA1});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("ovf_clear", alert_ovf, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 'h5F),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 'h50), $urandom_range(0, 'h5F),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3), $urandom_range(0, 2) != 0);
            cycle();
        end

        // Lock every ID with a pending alert, then reset mid-operation
        for (int k = 0; k < 12; k++) begin
            drive(1, k % 4, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        check("pre_rst_state", {locked, alert_valid}, {4'hF, 1'b1});
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("rst_all", {chk_valid, chk_allow, chk_block, locked, alert_valid,
                          alert_id, alert_addr, alert_data, alert_ovf}, 32'h0);
        rst = 1'b0;
        drive(1, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("post_rst_block", {chk_block, alert_valid, alert_id, alert_addr},
              {1'b1, 1'b1, 2'd1, 8'h10});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
